cvm300_pixel_packer: RTL and testbench
======================================

// Module: cvm300_pixel_packer
// PURPOSE
//  Sits between the CVM300 pixel capture path and the USB pipe-out FIFO. Takes one
//  10-bit pixel per pix_valid strobe, keeps the top 8 bits, packs 4 pixels per 32-bit
//  FIFO word and counts pixels against a fixed frame size. Tracks words written but
//  not yet drained so USB_ready is raised only when a full block-throttle block is there.
// PARAMETERS
//  PIX_PER_FRAME  316224  pixels per frame (648x488); any value >= 1
//  BLOCK_WORDS    256     32-bit words per USB block-throttled transfer; >= 1
//  CNT_W          20      width of pixel and pending-word counters
// PORTS
//  clk             in   1   system clock; sole clock
//  rst_n           in   1   asynchronous active-low reset
//  frame_start     in   1   1-cycle pulse: begin a new frame; clears packer and flags
//  pix_valid       in   1   1-cycle strobe: pix_data holds a valid pixel
//  pix_data        in   10  pixel sample; bits [9:2] are packed
//  FIFO_full       in   1   FIFO cannot accept a write this cycle
//  FIFO_BT         in   1   1-cycle pulse: host has drained one block
//  FIFO_wr_enable  out  1   write strobe to FIFO, 1 cycle per word
//  FIFO_data_in    out  32  packed word; pixel n at bits [8n+7:8n], n=0 first
//  USB_ready       out  1   pending words >= BLOCK_WORDS
//  frame_done      out  1   level: whole frame pushed, held until next frame_start
//  overflow        out  1   sticky: a word was dropped due to FIFO_full
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; pixel/lane/pending counters 0; shift reg 0.
//  FSM IDLE -> PACK on frame_start. PACK -> FLUSH when pixel PIX_PER_FRAME accepted
//  and lane != 3 after it (partial word); PACK -> DONE when it lands in lane 3.
//  FLUSH -> DONE after 1 cycle. DONE -> PACK on frame_start.
//  frame_start in any state: lane=0, pixel count=0, shift reg=0, overflow=0,
//  frame_done=0, pending=0, USB_ready=0; state=PACK. It overrides a pix_valid
//  in the same cycle (that pixel dropped).
//  PACK: pix_valid writes pix_data[9:2] to lane lane_idx, lane_idx++ (mod 4).
//  When lane 3 is filled: FIFO_wr_enable=1 next cycle with the 4 packed bytes.
//  Latency: 4th pixel strobe at cycle t -> write strobe at t+1.
//  FLUSH: emit remaining lanes with unfilled lanes = 8'h00; one write strobe.
//  pix_valid in IDLE/FLUSH/DONE is ignored; pixel count never exceeds PIX_PER_FRAME.
//  FIFO_full sampled in the cycle the word would be written: if 1, no strobe,
//  word discarded, overflow<=1, pending not incremented. Packing continues.
//  pending: +1 per issued write, -BLOCK_WORDS per FIFO_BT (saturate at 0);
//  both in the same cycle -> net update. USB_ready registered: pending>=BLOCK_WORDS
//  evaluated on the updated value, so it drops the cycle after FIFO_BT.
//  frame_done rises on entry to DONE, cycle after the last write strobe.
//  Back-to-back pix_valid every cycle supported with no stall or loss.
//  rst_n low mid-frame: immediate return to reset values; partial word lost.
// TESTING
//  1) PIX_PER_FRAME=8: frame_start, pixels 10'h004,008,00C,010 -> word 32'h04030201
//     one cycle after 4th strobe; 4 more -> 2nd word, frame_done=1, 2 strobes total.
//  2) PIX_PER_FRAME=6: 6 pixels 10'h3FC -> words 32'hFFFFFFFF then 32'h0000FFFF
//     via FLUSH; frame_done=1; 7th pix_valid ignored, no 3rd strobe.
//  3) BLOCK_WORDS=2, 12 pixels continuous -> USB_ready=1 after 2nd write; FIFO_BT
//     coincident with 3rd write -> pending=1, USB_ready=0.
//  4) FIFO_full=1 during 2nd word -> no strobe for it, overflow=1 sticky, 3rd word
//     normal; next frame_start clears overflow.
//  5) rst_n low after 2 pixels -> all outputs 0 asynchronously; after release,
//     frame_start + 4 pixels -> single clean word, no residue from old lanes.
//  6) frame_start in same cycle as pix_valid mid-frame -> pixel dropped, lane=0,
//     pending=0, next 4 pixels form first word of new frame.

Source files
------------

// File: rtl/cvm300_pixel_packer.sv
// Packs the top 8 bits of four CVM300 pixels into each 32-bit USB pipe-out FIFO word.
// It also tracks undrained words so the host sees USB_ready once a full block is queued.
module cvm300_pixel_packer #(
    parameter int PIX_PER_FRAME = 316224,
    parameter int BLOCK_WORDS   = 256,
    parameter int CNT_W         = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [9:0]  pix_data,
    input  logic        FIFO_full,
    input  logic        FIFO_BT,
    output logic        FIFO_wr_enable,
    output logic [31:0] FIFO_data_in,
    output logic        USB_ready,
    output logic        frame_done,
    output logic        overflow
);

    typedef enum logic [1:0] {IDLE, PACK, FLUSH, DONE} state_t;

    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(PIX_PER_FRAME - 1);
    localparam logic [CNT_W-1:0] BLOCK      = CNT_W'(BLOCK_WORDS);

    state_t           state;
    logic [1:0]       lane;
    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] pending;
    logic [23:0]      shift_reg;

    logic             accept;
    logic             last_pix;
    logic             issue;
    logic [31:0]      word_next;
    logic [CNT_W-1:0] pending_inc;
    logic [CNT_W-1:0] pending_next;
    logic             pix_lsbs_unused;

    assign pix_lsbs_unused = ^pix_data[1:0];

    // Lane 3 bypasses the shift register, so a word can leave the cycle its last byte arrives.
    always_comb begin
        accept       = (state == PACK) && pix_valid;
        last_pix     = accept && (pix_cnt == FRAME_LAST);
        issue        = (accept && (lane == 2'd3)) || (state == FLUSH);
        word_next    = (state == FLUSH) ? {8'h00, shift_reg} : {pix_data[9:2], shift_reg};
        pending_inc  = pending + {{(CNT_W-1){1'b0}}, FIFO_wr_enable};
        pending_next = pending_inc;
        if (FIFO_BT) begin
            pending_next = (pending_inc >= BLOCK) ? (pending_inc - BLOCK) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            lane           <= 2'd0;
            pix_cnt        <= '0;
            pending        <= '0;
            shift_reg      <= 24'h0;
            FIFO_wr_enable <= 1'b0;
            FIFO_data_in   <= 32'h0;
            USB_ready      <= 1'b0;
            frame_done     <= 1'b0;
            overflow       <= 1'b0;
        end else if (frame_start) begin
            state          <= PACK;
            lane           <= 2'd0;
            pix_cnt        <= '0;
            pending        <= '0;
            shift_reg      <= 24'h0;
            FIFO_wr_enable <= 1'b0;
            USB_ready      <= 1'b0;
            frame_done     <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            FIFO_wr_enable <= 1'b0;
            pending        <= pending_next;
            USB_ready      <= (pending_next >= BLOCK);
            if (issue) begin
                if (FIFO_full) begin
                    overflow <= 1'b1;
                end else begin
                    FIFO_wr_enable <= 1'b1;
                    FIFO_data_in   <= word_next;
                end
            end
            case (state)
                PACK: begin
                    if (accept) begin
                        lane    <= lane + 2'd1;
                        pix_cnt <= pix_cnt + CNT_W'(1);
                        case (lane)
                            2'd0:    shift_reg[7:0]   <= pix_data[9:2];
                            2'd1:    shift_reg[15:8]  <= pix_data[9:2];
                            2'd2:    shift_reg[23:16] <= pix_data[9:2];
                            default: shift_reg        <= 24'h0;
                        endcase
                        if (last_pix) begin
                            state <= (lane == 2'd3) ? DONE : FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    shift_reg <= 24'h0;
                    lane      <= 2'd0;
                    state     <= DONE;
                end
                DONE: begin
                    frame_done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cvm300_pixel_packer.sv
// Randomised plus directed bench for cvm300_pixel_packer, checked each cycle against
// a queue-based model of frames, words, and the pending-block count.
module tb_cvm300_pixel_packer;

    localparam int PPF   = 14;
    localparam int BW    = 2;
    localparam int CW    = 20;
    localparam int MAXC  = 4000;
    localparam int NEVER = 1 << 30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [9:0]  pix_data = 10'h0;
    logic        FIFO_full = 1'b0;
    logic        FIFO_BT = 1'b0;
    logic        FIFO_wr_enable;
    logic [31:0] FIFO_data_in;
    logic        USB_ready;
    logic        frame_done;
    logic        overflow;

    cvm300_pixel_packer #(
        .PIX_PER_FRAME(PPF),
        .BLOCK_WORDS  (BW),
        .CNT_W        (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_start   (frame_start),
        .pix_valid     (pix_valid),
        .pix_data      (pix_data),
        .FIFO_full     (FIFO_full),
        .FIFO_BT       (FIFO_BT),
        .FIFO_wr_enable(FIFO_wr_enable),
        .FIFO_data_in  (FIFO_data_in),
        .USB_ready     (USB_ready),
        .frame_done    (frame_done),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_pv = -10;
    logic ff_cur = 1'b0;

    // Model: words expected on the FIFO port, indexed by the cycle their strobe appears.
    bit          sched_wr[MAXC];
    logic [31:0] sched_data[MAXC];
    bit          in_frame;
    int          npix;
    logic [7:0]  q[$];
    bit          m_ovf;
    bit          m_usb;
    int          pend;
    int          done_cycle;
    int          flush_at;

    task automatic expect1(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, req);
        end
    endtask

    function automatic logic [31:0] packq();
        logic [31:0] w;
        w = 32'h0;
        foreach (q[i]) w[8*i +: 8] = q[i];
        return w;
    endfunction

    task automatic modelIssue(input int c, input logic ff);
        if (ff) begin
            m_ovf = 1'b1;
        end else begin
            sched_wr[c+1]   = 1'b1;
            sched_data[c+1] = packq();
        end
        q.delete();
    endtask

    task automatic modelReset();
        in_frame   = 1'b0;
        npix       = 0;
        q.delete();
        m_ovf      = 1'b0;
        m_usb      = 1'b0;
        pend       = 0;
        done_cycle = NEVER;
        flush_at   = -1;
        for (int i = cyc; i < cyc + 4; i++) sched_wr[i] = 1'b0;
    endtask

    task automatic modelStep(input logic fs, input logic pv, input logic [9:0] pd,
                             input logic ff, input logic bt);
        int c;
        c = cyc;
        if (fs) begin
            in_frame   = 1'b1;
            npix       = 0;
            q.delete();
            m_ovf      = 1'b0;
            m_usb      = 1'b0;
            pend       = 0;
            done_cycle = NEVER;
            flush_at   = -1;
        end else begin
            pend = pend + (sched_wr[c] ? 1 : 0);
            if (bt) pend = (pend >= BW) ? pend - BW : 0;
            m_usb = (pend >= BW);
            if (flush_at == c) begin
                modelIssue(c, ff);
                flush_at = -1;
            end
            if (pv && in_frame) begin
                q.push_back(pd[9:2]);
                npix++;
                if (q.size() == 4) modelIssue(c, ff);
                if (npix == PPF) begin
                    in_frame = 1'b0;
                    if (q.size() > 0) begin
                        flush_at   = c + 1;
                        done_cycle = c + 3;
                    end else begin
                        done_cycle = c + 2;
                    end
                end
            end
        end
    endtask

    task automatic checkOutput();
        expect1("wr_enable", FIFO_wr_enable, sched_wr[cyc]);
        if (sched_wr[cyc]) expect1("data", FIFO_data_in, sched_data[cyc]);
        expect1("usb_ready", USB_ready, m_usb);
        expect1("frame_done", frame_done, cyc >= done_cycle);
        expect1("overflow", overflow, m_ovf);
    endtask

    task automatic applyStimulus(input logic fs, input logic pv, input logic [9:0] pd,
                                 input logic ff, input logic bt);
        frame_start = fs;
        pix_valid   = pv;
        pix_data    = pd;
        FIFO_full   = ff;
        FIFO_BT     = bt;
        modelStep(fs, pv, pd, ff, bt);
        if (pv) last_pv = cyc;
        @(posedge clk);
        #1;
        cyc++;
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 10'h0, ff_cur, 1'b0);
    endtask

    task automatic pixel(input logic [9:0] pd);
        applyStimulus(1'b0, 1'b1, pd, ff_cur, 1'b0);
    endtask

    initial begin
        #(MAXC * 10 - 100);
        $display("[TB] FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [9:0] lit_px[4];
        int         nc;
        bit         dense;
        lit_px = '{10'h004, 10'h008, 10'h00C, 10'h010};

        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput();
        expect1("reset_data", FIFO_data_in, 32'h0);
        rst_n = 1'b1;

        // Pixels before any frame_start must be ignored.
        pixel(10'h3FC);
        pixel(10'h155);
        idle(2);

        // Directed frame: first word from known pixels, then a flushed partial word.
        applyStimulus(1'b1, 1'b0, 10'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) pixel(lit_px[i]);
        expect1("lit_w0_en", FIFO_wr_enable, 1'b1);
        expect1("lit_w0", FIFO_data_in, 32'h04030201);
        expect1("lit_w0_model", sched_data[cyc], 32'h04030201);
        for (int i = 0; i < 10; i++) pixel(10'h3FC);
        idle(1);
        expect1("lit_flush_en", FIFO_wr_enable, 1'b1);
        expect1("lit_flush", FIFO_data_in, 32'h0000FFFF);
        expect1("lit_flush_model", sched_data[cyc], 32'h0000FFFF);
        idle(1);
        expect1("lit_done", frame_done, 1'b1);
        expect1("lit_usb4", USB_ready, 1'b1);
        pixel(10'h3FC);
        idle(3);

        // FIFO_BT landing on the third write of a fresh frame.
        applyStimulus(1'b1, 1'b0, 10'h0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            pixel(10'($urandom_range(0, 1023)));
            if (i == 8) expect1("lit_usb_after2", USB_ready, 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 10'h0, 1'b0, 1'b1);
        expect1("lit_usb_bt", USB_ready, 1'b0);
        expect1("lit_pend_model", pend, 1);
        pixel(10'h111);
        pixel(10'h222);
        idle(4);

        // Overflow on the second word, sticky until the next frame_start.
        applyStimulus(1'b1, 1'b0, 10'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) pixel(10'($urandom_range(0, 1023)));
        ff_cur = 1'b1;
        for (int i = 0; i < 4; i++) pixel(10'($urandom_range(0, 1023)));
        idle(1);
        ff_cur = 1'b0;
        idle(1);
        expect1("lit_ovf", overflow, 1'b1);
        for (int i = 0; i < 4; i++) pixel(10'($urandom_range(0, 1023)));
        expect1("lit_w3_en", FIFO_wr_enable, 1'b1);
        pixel(10'h0F0);
        pixel(10'h00F);
        idle(4);
        expect1("lit_ovf_held", overflow, 1'b1);
        applyStimulus(1'b1, 1'b0, 10'h0, 1'b0, 1'b0);
        expect1("lit_ovf_clr", overflow, 1'b0);

        // Asynchronous reset mid-word, then a clean word with no old lanes.
        pixel(10'h3FC);
        pixel(10'h3FC);
        rst_n = 1'b0;
        #1;
        expect1("rst_wr", FIFO_wr_enable, 1'b0);
        expect1("rst_data", FIFO_data_in, 32'h0);
        expect1("rst_usb", USB_ready, 1'b0);
        expect1("rst_done", frame_done, 1'b0);
        expect1("rst_ovf", overflow, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc++;
        modelReset();
        checkOutput();
        applyStimulus(1'b1, 1'b0, 10'h0, 1'b0, 1'b0);
        pixel(10'h100);
        pixel(10'h200);
        pixel(10'h300);
        pixel(10'h004);
        expect1("lit_clean", FIFO_data_in, 32'h01C08040);
        expect1("lit_clean_model", sched_data[cyc], 32'h01C08040);

        // frame_start colliding with a pixel mid-frame drops that pixel.
        pixel(10'h3FC);
        pixel(10'h3FC);
        applyStimulus(1'b1, 1'b1, 10'h3FC, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) pixel(lit_px[i]);
        expect1("lit_restart", FIFO_data_in, 32'h04030201);
        for (int i = 0; i < 10; i++) pixel(10'($urandom_range(0, 1023)));
        idle(4);

        // Random frames: gaps, bursts, aborts, block drains and FIFO-full windows.
        for (int f = 0; f < 30; f++) begin
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)),
                          ff_cur, 1'($urandom_range(0, 9) == 0));
            nc    = $urandom_range(10, 45);
            dense = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < nc; i++) begin
                if ((cyc - last_pv >= 3) && ($urandom_range(0, 5) == 0)) ff_cur = ~ff_cur;
                applyStimulus(1'b0,
                              1'($urandom_range(0, 99) < (dense ? 90 : 40)),
                              10'($urandom_range(0, 1023)),
                              ff_cur,
                              1'($urandom_range(0, 99) < 10));
            end
        end
        ff_cur = 1'b0;
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
